// File: rtl/quad_encoder_pkg.sv
// Shared state encodings and detent constants for the quadrature encoder.
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } enc_state_t;

  localparam int QUARTERS_PER_DETENT = 4;

  // Clockwise successor in the Gray sequence S11 -> S10 -> S00 -> S01 -> S11.
  function automatic enc_state_t cw_next(input enc_state_t s);
    case (s)
      S11:     cw_next = S10;
      S10:     cw_next = S00;
      S00:     cw_next = S01;
      default: cw_next = S11;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_debouncer.sv
// Two-flop synchroniser followed by a hold-N-cycles debounce filter.
module debouncer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(N);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(N - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder.sv
// Debounced quadrature decoder: counts full detents into a saturating or wrapping value.
module quad_encoder
  import quad_encoder_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_VALUE     = 0,
  parameter int WRAP            = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] value,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             error
);

  localparam logic [WIDTH-1:0]  RST_V     = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]  VMAX      = '1;
  localparam logic signed [3:0] Q_FULL    = 4'(QUARTERS_PER_DETENT);
  localparam logic signed [3:0] Q_FULL_N  = 4'(-QUARTERS_PER_DETENT);

  logic              deb_a;
  logic              deb_b;
  enc_state_t        st;
  enc_state_t        cur;
  logic signed [3:0] q;
  logic signed [3:0] q_step;
  logic              is_cw;
  logic              is_ccw;
  logic [WIDTH-1:0]  value_inc;
  logic [WIDTH-1:0]  value_dec;

  debouncer #(.N(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a),
    .deb   (deb_a)
  );

  debouncer #(.N(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b),
    .deb   (deb_b)
  );

  always_comb begin
    cur       = enc_state_t'({deb_a, deb_b});
    is_cw     = (cur == cw_next(st));
    is_ccw    = (st == cw_next(cur));
    q_step    = is_cw ? q + 4'sd1 : q - 4'sd1;
    value_inc = (WRAP != 0 || value != VMAX) ? value + WIDTH'(1) : value;
    value_dec = (WRAP != 0 || value != '0)   ? value - WIDTH'(1) : value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S11;
      q        <= '0;
      value    <= RST_V;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      error    <= 1'b0;
    end else begin
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      error    <= 1'b0;
      if (cur != st) begin
        st <= cur;
        if (is_cw || is_ccw) begin
          // The detent position commits the accumulated quarter steps, then restarts.
          if (cur == S11) begin
            q <= '0;
            if (q_step == Q_FULL) begin
              step_cw <= 1'b1;
              value   <= value_inc;
            end else if (q_step == Q_FULL_N) begin
              step_ccw <= 1'b1;
              value    <= value_dec;
            end
          end else begin
            q <= q_step;
          end
        end else begin
          q     <= '0;
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder.sv
// Directed bench for quad_encoder: three parameterisations checked against a position-arithmetic model.
module tb_quad_encoder;

  localparam int N = 4;
  localparam int W  [3] = '{8, 8, 2};
  localparam int RV [3] = '{2, 0, 3};
  localparam int WR [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b1;
  logic b = 1'b1;

  logic [7:0] v0, v1;
  logic [1:0] v2;
  logic cw0, ccw0, er0, cw1, ccw1, er1, cw2, ccw2, er2;

  always #5 clk = ~clk;

  quad_encoder #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .RESET_VALUE(2), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .value(v0), .step_cw(cw0), .step_ccw(ccw0), .error(er0));

  quad_encoder #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .RESET_VALUE(0), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .value(v1), .step_cw(cw1), .step_ccw(ccw1), .error(er1));

  quad_encoder #(.WIDTH(2), .DEBOUNCE_CYCLES(N), .RESET_VALUE(3), .WRAP(0)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .value(v2), .step_cw(cw2), .step_ccw(ccw2), .error(er2));

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;
  int n_cw = 0, n_ccw = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the raw pin has shown the opposite level
  // for N consecutive samples, seen two samples late. Detents are tracked as
  // positions 0..3 around the Gray cycle.
  bit hist_a [0:N];
  bit hist_b [0:N];
  bit mdeb_a, mdeb_b;
  int mpos, mq;
  bit m_cw, m_ccw, m_err;
  int mval [3];

  function automatic int pos_of(input bit x, input bit y);
    case ({x, y})
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int bump(input int d, input int v, input int dirn);
    int maxv;
    int nv;
    maxv = (1 << W[d]) - 1;
    nv = v + dirn;
    if (WR[d] != 0) nv = (nv + maxv + 1) % (maxv + 1);
    else if (nv > maxv) nv = maxv;
    else if (nv < 0) nv = 0;
    return nv;
  endfunction

  always @(posedge clk) begin : model
    bit ncw, nccw, nerr, flip_a, flip_b;
    int npos, nq, dir;
    int nv [3];
    if (reset) begin
      for (int i = 0; i <= N; i++) begin
        hist_a[i] <= 1'b1;
        hist_b[i] <= 1'b1;
      end
      mdeb_a <= 1'b1; mdeb_b <= 1'b1;
      mpos <= 0; mq <= 0;
      m_cw <= 1'b0; m_ccw <= 1'b0; m_err <= 1'b0;
      for (int d = 0; d < 3; d++) mval[d] <= RV[d];
    end else begin
      ncw = 1'b0; nccw = 1'b0; nerr = 1'b0;
      npos = pos_of(mdeb_a, mdeb_b);
      nq = mq;
      for (int d = 0; d < 3; d++) nv[d] = mval[d];
      dir = (npos - mpos + 4) % 4;
      if (dir == 2) begin
        nerr = 1'b1;
        nq = 0;
      end else if (dir != 0) begin
        nq = (dir == 1) ? mq + 1 : mq - 1;
        if (npos == 0) begin
          if (nq == 4) begin
            ncw = 1'b1;
            for (int d = 0; d < 3; d++) nv[d] = bump(d, mval[d], 1);
          end else if (nq == -4) begin
            nccw = 1'b1;
            for (int d = 0; d < 3; d++) nv[d] = bump(d, mval[d], -1);
          end
          nq = 0;
        end
      end
      mpos <= npos; mq <= nq;
      m_cw <= ncw; m_ccw <= nccw; m_err <= nerr;
      for (int d = 0; d < 3; d++) mval[d] <= nv[d];
      flip_a = 1'b1; flip_b = 1'b1;
      for (int i = 1; i <= N; i++) begin
        if (hist_a[i] == mdeb_a) flip_a = 1'b0;
        if (hist_b[i] == mdeb_b) flip_b = 1'b0;
      end
      if (flip_a) mdeb_a <= ~mdeb_a;
      if (flip_b) mdeb_b <= ~mdeb_b;
      hist_a[0] <= a;
      hist_b[0] <= b;
      for (int i = 1; i <= N; i++) begin
        hist_a[i] <= hist_a[i-1];
        hist_b[i] <= hist_b[i-1];
      end
    end
  end

  always @(negedge clk) begin : compare
    if (armed) begin
      chk("value0", 32'(v0), mval[0]);
      chk("value1", 32'(v1), mval[1]);
      chk("value2", 32'(v2), mval[2]);
      chk("step_cw0", 32'(cw0), 32'(m_cw));
      chk("step_cw1", 32'(cw1), 32'(m_cw));
      chk("step_cw2", 32'(cw2), 32'(m_cw));
      chk("step_ccw0", 32'(ccw0), 32'(m_ccw));
      chk("step_ccw1", 32'(ccw1), 32'(m_ccw));
      chk("step_ccw2", 32'(ccw2), 32'(m_ccw));
      chk("error0", 32'(er0), 32'(m_err));
      chk("error1", 32'(er1), 32'(m_err));
      chk("error2", 32'(er2), 32'(m_err));
      n_cw  += int'(cw0);
      n_ccw += int'(ccw0);
      n_err += int'(er0);
    end
  end

  task automatic hold(input bit pa, input bit pb, input int n);
    a = pa;
    b = pb;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cw = 0; n_ccw = 0; n_err = 0;
  endtask

  task automatic cw_detent();
    hold(1, 0, 6); hold(0, 0, 6); hold(0, 1, 6); hold(1, 1, 10);
  endtask

  task automatic ccw_detent();
    hold(0, 1, 6); hold(0, 0, 6); hold(1, 0, 6); hold(1, 1, 10);
  endtask

  int lat;
  logic [7:0] base;
  int exp_ccw [5] = '{1, 0, 0, 0, 0};

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    n_cw = 0; n_ccw = 0; n_err = 0;

    hold(1, 1, 20);
    chk("reset_value0", 32'(v0), 2);
    chk("reset_value1", 32'(v1), 0);
    chk("reset_value2", 32'(v2), 3);
    chk("reset_no_pulses", n_cw + n_ccw + n_err, 0);

    // One CW detent, measuring edges from first sample of 11 to the value change.
    hold(1, 0, 6); hold(0, 0, 6); hold(0, 1, 6);
    a = 1'b1; b = 1'b1;
    base = v0;
    lat = 99;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (v0 != base) begin
        lat = k;
        break;
      end
    end
    chk("cw_latency", lat, N + 2);
    hold(1, 1, 6);
    chk("cw_value0", 32'(v0), 3);
    chk("cw_value1", 32'(v1), 1);
    chk("cw_saturate_top", 32'(v2), 3);
    chk("cw_pulse_count", n_cw, 1);

    pulse_reset();
    hold(1, 1, 8);
    for (int i = 0; i < 5; i++) begin
      ccw_detent();
      chk("ccw_value0", 32'(v0), exp_ccw[i]);
      if (i == 0) chk("ccw_wrap_value1", 32'(v1), 255);
    end
    chk("ccw_pulse_count", n_ccw, 5);
    chk("ccw_value2_floor", 32'(v2), 0);

    pulse_reset();
    hold(1, 1, 8);
    ccw_detent();
    chk("wrap_down", 32'(v1), 255);
    cw_detent();
    chk("wrap_up", 32'(v1), 0);
    chk("wrap_sat_value0", 32'(v0), 2);

    n_cw = 0; n_ccw = 0; n_err = 0;
    hold(0, 1, 3);
    hold(1, 1, 10);
    chk("glitch_no_pulses", n_cw + n_ccw + n_err, 0);
    chk("glitch_value0", 32'(v0), 2);

    hold(0, 0, 10);
    chk("illegal_error", n_err, 1);
    chk("illegal_value0", 32'(v0), 2);
    hold(1, 1, 10);
    chk("illegal_back_error", n_err, 2);
    chk("illegal_no_steps", n_cw + n_ccw, 0);

    n_cw = 0; n_ccw = 0; n_err = 0;
    hold(1, 0, 6);
    hold(0, 0, 6);
    pulse_reset();
    hold(0, 0, 8);
    hold(0, 1, 6);
    hold(1, 1, 10);
    chk("midreset_value0", 32'(v0), 2);
    chk("midreset_value1", 32'(v1), 0);
    chk("midreset_no_steps", n_cw + n_ccw, 0);
    chk("midreset_error", n_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
